jpeg_dezigzag_stream: RTL
=========================

Name: jpeg_dezigzag_stream

Overview:
- Streaming, double-buffered inverse-zigzag stage between the Huffman/run-length decoder and dequantiser/IDCT.
- Accepts sparse coefficients, one per cycle, tagged with their zigzag index. Positions not written in a block read as zero.
- Emits all 64 coefficients of each block serially in row-major order, or column-major when TRANSPOSE=1.
- Two banks, so one block can be filled while the previous block drains.

Parameters:
- WIDTH, 16: coefficient width in bits, signed two's complement; data passes through unmodified.
- TRANSPOSE, 0: 0 = row-major output; 1 = column-major output (the transposed block).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  block can accept a coefficient.
- in_data  in  WIDTH  coefficient value.
- in_idx  in  6  zigzag index of in_data, 0..63.
- in_last  in  1  final coefficient of the block (EOB or index 63); sampled only with in_valid.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  coefficient in raster order; zero for unwritten positions.
- out_last  out  1  high with the 64th output of a block.
- err_order  out  1  sticky ordering error (see Optional Feature).

Behaviour:
- Reset:
  - Both banks EMPTY; written-masks cleared; wr_bank = rd_bank = 0; output counter = 0.
  - in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, err_order = 0.
  - Reset asserted mid-block or mid-drain discards all buffered data.
- Storage:
  - 2 banks x 64 x WIDTH registers, plus a 64-bit written-mask per bank.
  - Zigzag index z maps to raster position p = 8*row + col using the standard JPEG zigzag scan (z0 -> p0, z1 -> p1, z2 -> p8, z3 -> p16, z4 -> p9, z5 -> p2, ..., z63 -> p63). Implemented as a constant table.
- Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY -> FILLING: on the first accepted write.
  - FILLING -> FULL: on an accepted write with in_last; wr_bank toggles at the same edge.
  - FULL -> DRAINING: on the first output handshake.
  - DRAINING -> EMPTY: on the handshake with out_last; the bank's mask clears and rd_bank toggles at the same edge.
  - A block with in_last on its first write (DC only) goes EMPTY -> FULL directly.
- Input handshake:
  - in_ready = state[wr_bank] is EMPTY or FILLING.
  - Transfer occurs when in_valid && in_ready: writes data[wr_bank][p], sets mask bit p.
  - A repeated index within a block overwrites the earlier value (last write wins).
- Output handshake:
  - out_valid = state[rd_bank] is FULL or DRAINING.
  - Counter k = 0..63. Source position p = k when TRANSPOSE=0, p = 8*(k%8) + k/8 when TRANSPOSE=1.
  - out_data = mask[p] ? data[rd_bank][p] : 0. Data is combinational from the registers and is held stable while out_valid && !out_ready.
  - out_last = out_valid && (k == 63).
  - k increments on each handshake and wraps 63 -> 0.
- Latency: first out_valid in the cycle immediately after the edge that accepted in_last, provided rd_bank points at that bank. Minimum block period is 64 cycles on output.
- Concurrency:
  - A simultaneous write to wr_bank and drain of rd_bank is legal because the banks always differ while both are active.
  - With both banks FULL/DRAINING, in_ready = 0 until the drain completes; in_ready rises the cycle after the out_last handshake.
  - Same-edge release and refill: on the edge where a bank returns to EMPTY, it is not also written.
- in_idx is 6 bits, so no out-of-range index is possible.

Optional Feature:
- Macro: JPEG_DZZ_ORDER_CHK_EN.
- Defined:
  - Tracks the last accepted index per block.
  - An accepted write with in_idx <= previous index (not the block's first write) sets err_order high until reset.
  - The data is still written.
- Undefined: err_order is tied to 0 and no tracking logic is built.

Test Plan:
- Dense block: indices 0..63 with data = index + 100, in_last on 63, out_ready = 1. Expect outputs for raster 0..7 of 100, 101, 105, 106, 114, 115, 127, 128. out_last on the 64th output; first out_valid 1 cycle after in_last is accepted.
- Sparse EOB: idx 0 = -5, idx 2 = 7, in_last on idx 2. Expect raster p0 = -5, p8 = 7, the other 62 outputs 0, out_last on the 64th.
- Back-pressure/ping-pong: three back-to-back dense blocks with out_ready low for 100 cycles. Expect in_ready to drop after block 2 completes, no data loss, and blocks emitted in order once out_ready = 1.
- TRANSPOSE=1 with the dense block: output sequence starts 100, 102, 103, 109, 110, 120, 121, 135.
- Reset mid-drain after 20 outputs: out_valid = 0 next cycle and in_ready = 1. A new sparse block then outputs correctly with no stale nonzero values.
- With JPEG_DZZ_ORDER_CHK_EN defined: indices 0, 3, 2 give err_order = 1 from the cycle after idx 2 is accepted. In a build without the macro, err_order stays 0.

Source files
------------

// File: rtl/jpeg_dezigzag_stream.sv
// Double-buffered inverse-zigzag stage: sparse zigzag-indexed writes in, 64 raster-order coefficients out.
// Optional index-ordering checker enabled by defining JPEG_DZZ_ORDER_CHK_EN.
module jpeg_dezigzag_stream #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TRANSPOSE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [5:0]       in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             err_order
);

  localparam int unsigned NCOEF = 64;
  localparam int unsigned IDXW  = 6;
  localparam int unsigned NBANK = 2;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Zigzag scan index -> raster position (8*row + col).
  localparam logic [IDXW-1:0] ZZ2RASTER [NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  bank_state_e      state_q [NBANK];
  bank_state_e      state_d [NBANK];
  logic [NCOEF-1:0] mask_q  [NBANK];
  logic [NCOEF-1:0] mask_d  [NBANK];
  logic [WIDTH-1:0] data_q  [NBANK][NCOEF];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDXW-1:0]  k_q, k_d;

  logic             in_fire;
  logic             out_fire;
  logic [IDXW-1:0]  wr_pos;
  logic [IDXW-1:0]  rd_pos;

  assign wr_pos   = ZZ2RASTER[in_idx];
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Column-major read swaps the row and column fields of the counter.
  generate
    if (TRANSPOSE != 0) begin : g_col_major
      assign rd_pos = {k_q[2:0], k_q[5:3]};
    end else begin : g_row_major
      assign rd_pos = k_q;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < int'(NBANK); b++) begin
        state_q[b] <= EMPTY;
        mask_q[b]  <= '0;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      k_q       <= '0;
    end else begin
      for (int b = 0; b < int'(NBANK); b++) begin
        state_q[b] <= state_d[b];
        mask_q[b]  <= mask_d[b];
      end
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      k_q       <= k_d;
    end
  end

  // Coefficient storage; unwritten entries are masked on read so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst_n && in_fire) begin
      data_q[wr_bank_q][wr_pos] <= in_data;
    end
  end

  // Next-state logic. The write bank is EMPTY/FILLING and the read bank is
  // FULL/DRAINING whenever they fire, so the two updates never hit the same bank.
  always_comb begin
    for (int b = 0; b < int'(NBANK); b++) begin
      state_d[b] = state_q[b];
      mask_d[b]  = mask_q[b];
    end
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    k_d       = k_q;

    if (in_fire) begin
      mask_d[wr_bank_q][wr_pos] = 1'b1;
      if (in_last) begin
        state_d[wr_bank_q] = FULL;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = FILLING;
      end
    end

    if (out_fire) begin
      k_d = k_q + IDXW'(1);
      if (k_q == IDXW'(NCOEF - 1)) begin
        state_d[rd_bank_q] = EMPTY;
        mask_d[rd_bank_q]  = '0;
        rd_bank_d          = ~rd_bank_q;
      end else begin
        state_d[rd_bank_q] = DRAINING;
      end
    end
  end

  // Handshake and output data decode.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    in_ready  = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
    out_valid = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);
    out_last  = out_valid && (k_q == IDXW'(NCOEF - 1));
    if (mask_q[rd_bank_q][rd_pos]) begin
      out_data = data_q[rd_bank_q][rd_pos];
    end
  end

`ifdef JPEG_DZZ_ORDER_CHK_EN
  logic [IDXW-1:0] prev_idx_q;
  logic            err_q;

  // Sticky flag for a non-increasing index after the first write of a block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_idx_q <= '0;
      err_q      <= 1'b0;
    end else if (in_fire) begin
      prev_idx_q <= in_idx;
      if ((state_q[wr_bank_q] != EMPTY) && (in_idx <= prev_idx_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_order = err_q;
`else
  assign err_order = 1'b0;
`endif

endmodule
